// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default constants for the PC generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_BR   = 3'd3,
        SEL_TRAP = 3'd4
    } sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
    localparam int unsigned DEF_INC       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority arbiter
//
// Ports:
//   pc_i, pc_inc_i       current PC and its sequential successor
//   seq_ok_i             sequential advance permitted this cycle
//   trap_i               trap redirect to TRAP_VEC (highest priority)
//   br_taken_i/_target_i branch redirect
//   jmp_i/jmp_target_i   jump redirect
//   sel_o                chosen source
//   next_pc_o            PC value for the next edge
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_inc_i,
    input  logic            seq_ok_i,
    input  logic            trap_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    output sel_e            sel_o,
    output logic [XLEN-1:0] next_pc_o
);

    always_comb begin
        sel_o     = SEL_HOLD;
        next_pc_o = pc_i;
        if (trap_i) begin
            sel_o     = SEL_TRAP;
            next_pc_o = TRAP_VEC;
        end else if (br_taken_i) begin
            sel_o     = SEL_BR;
            next_pc_o = br_target_i;
        end else if (jmp_i) begin
            sel_o     = SEL_JMP;
            next_pc_o = jmp_target_i;
        end else if (seq_ok_i) begin
            sel_o     = SEL_SEQ;
            next_pc_o = pc_inc_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with redirect and halt
//
// Optional macro PC_PERF_EN adds redirect_cnt_o / stall_cnt_o saturating counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall_i              blocks sequential advance only
//   fetch_ready_i        fetch accepts pc_o this cycle
//   br_taken_i/_target_i branch redirect
//   jmp_i/jmp_target_i   jump redirect
//   trap_i               redirect to TRAP_VEC
//   halt_i               enter wait-for-interrupt
//   pc_o, pc_inc_o       current PC, PC + INC (wrapping)
//   pc_valid_o           PC offered to fetch (RUN state)
//   misalign_o           last loaded redirect target misaligned
//   halted_o             in HALT
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     INC        = DEF_INC,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int unsigned     ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            trap_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_inc_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
`ifdef PC_PERF_EN
    output logic [31:0]     redirect_cnt_o,
    output logic [31:0]     stall_cnt_o,
`endif
    output logic            halted_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    sel_e            sel;
    logic [XLEN-1:0] next_pc;
    logic            seq_ok;
    logic            redirect;

    assign pc_o       = pc_q;
    assign pc_inc_o   = pc_q + XLEN'(INC);
    assign pc_valid_o = (state_q == RUN);
    assign halted_o   = (state_q == HALT);
    assign misalign_o = misalign_q;

    // A halt request without a redirect freezes the PC even if fetch is ready.
    assign seq_ok   = pc_valid_o && fetch_ready_i && !stall_i && !halt_i;
    assign redirect = (sel == SEL_TRAP) || (sel == SEL_BR) || (sel == SEL_JMP);

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .pc_i         (pc_q),
        .pc_inc_i     (pc_inc_o),
        .seq_ok_i     (seq_ok),
        .trap_i       (trap_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .sel_o        (sel),
        .next_pc_o    (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = next_pc;
        misalign_d = misalign_q;
        if (redirect) begin
            misalign_d = |(next_pc & ALIGN_MASK);
        end
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i) state_d = HALT;
            HALT:    if (redirect) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_PERF_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
        if (pc_valid_o && !(fetch_ready_i && !stall_i) && !redirect &&
            (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a behavioural model
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_target_i = 32'h0;
    logic        trap_i = 1'b0;
    logic        halt_i = 1'b0;

    logic [31:0] pc_o, pc_inc_o, w_pc_o, w_pc_inc_o;
    logic        pc_valid_o, misalign_o, halted_o;
    logic        w_pc_valid_o, w_misalign_o, w_halted_o;
`ifdef PC_PERF_EN
    logic [31:0] redirect_cnt_o, stall_cnt_o, w_redirect_cnt_o, w_stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // model state: mode 0 = booting, 1 = running, 2 = halted
    logic [31:0] m_pc;
    int          m_mode;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
        .trap_i(trap_i), .halt_i(halt_i),
        .pc_o(pc_o), .pc_inc_o(pc_inc_o), .pc_valid_o(pc_valid_o),
        .misalign_o(misalign_o),
`ifdef PC_PERF_EN
        .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
        .halted_o(halted_o)
    );

    pc_gen #(.RESET_VEC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
        .trap_i(trap_i), .halt_i(halt_i),
        .pc_o(w_pc_o), .pc_inc_o(w_pc_inc_o), .pc_valid_o(w_pc_valid_o),
        .misalign_o(w_misalign_o),
`ifdef PC_PERF_EN
        .redirect_cnt_o(w_redirect_cnt_o), .stall_cnt_o(w_stall_cnt_o),
`endif
        .halted_o(w_halted_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        bit          redir;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_mode = 0; m_mis = 1'b0;
            return;
        end
        redir = trap_i || br_taken_i || jmp_i;
        tgt   = trap_i ? 32'h100 : (br_taken_i ? br_target_i : jmp_target_i);
        if (redir) begin
            m_pc  = tgt;
            m_mis = (tgt % 4) != 0;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt_i) m_mode = 2;
            else if (!redir && fetch_ready_i && !stall_i) m_pc = m_pc + 32'd4;
        end else if (redir) begin
            m_mode = 1;
        end
    endtask

    task automatic compare_model();
        check("pc", pc_o, m_pc);
        check("pc_inc", pc_inc_o, m_pc + 32'd4);
        check("valid", {31'd0, pc_valid_o}, {31'd0, m_mode == 1});
        check("halted", {31'd0, halted_o}, {31'd0, m_mode == 2});
        check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic clear_redirects();
        trap_i = 0; br_taken_i = 0; jmp_i = 0; halt_i = 0;
    endtask

    initial begin
        m_pc = 32'h0; m_mode = 0; m_mis = 1'b0;
        // reset and boot
        rst = 1; fetch_ready_i = 1;
        tick(); tick();
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", {31'd0, pc_valid_o}, 32'd0);
        check("rst_w_pc", w_pc_o, 32'hFFFF_FFF8);
        rst = 0;
        tick();
        check("boot_pc0", pc_o, 32'h0);
        check("boot_valid", {31'd0, pc_valid_o}, 32'd1);
        check("wrap0", w_pc_o, 32'hFFFF_FFF8);
        tick();
        check("seq4", pc_o, 32'h4);
        check("wrap1", w_pc_o, 32'hFFFF_FFFC);
        tick();
        check("seq8", pc_o, 32'h8);
        check("wrap2", w_pc_o, 32'h0000_0000);
        // stall then backpressure
        stall_i = 1;
        repeat (3) begin tick(); check("stall_hold", pc_o, 32'h8); end
        stall_i = 0; fetch_ready_i = 0;
        repeat (2) begin tick(); check("bp_hold", pc_o, 32'h8); end
        fetch_ready_i = 1;
        tick();
        check("seqC", pc_o, 32'hC);
        // priority
        jmp_i = 1; jmp_target_i = 32'h40; tick();
        check("jmp40", pc_o, 32'h40);
        trap_i = 1; br_taken_i = 1; br_target_i = 32'h200; jmp_target_i = 32'h300;
        tick();
        check("prio_trap", pc_o, 32'h100);
        check("prio_mis", {31'd0, misalign_o}, 32'd0);
        clear_redirects();
        br_taken_i = 1; br_target_i = 32'h202; tick();
        check("br_mis_pc", pc_o, 32'h202);
        check("br_mis", {31'd0, misalign_o}, 32'd1);
        clear_redirects();
        // halt
        jmp_i = 1; jmp_target_i = 32'h20; tick();
        clear_redirects();
        halt_i = 1; tick(); halt_i = 0;
        repeat (4) begin
            tick();
            check("halt_pc", pc_o, 32'h20);
            check("halt_flag", {31'd0, halted_o}, 32'd1);
            check("halt_valid", {31'd0, pc_valid_o}, 32'd0);
        end
        jmp_i = 1; jmp_target_i = 32'h80; tick(); clear_redirects();
        check("wake_pc", pc_o, 32'h80);
        check("wake_valid", {31'd0, pc_valid_o}, 32'd1);
        check("wake_halted", {31'd0, halted_o}, 32'd0);
        // reset mid-halt
        halt_i = 1; tick(); halt_i = 0;
        rst = 1; tick();
        check("rh_pc", pc_o, 32'h0);
        check("rh_halted", {31'd0, halted_o}, 32'd0);
        check("rh_valid", {31'd0, pc_valid_o}, 32'd0);
        rst = 0; tick();
        check("rh_run", {31'd0, pc_valid_o}, 32'd1);
        // randomized phase
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 99) < 2);
            stall_i       = ($urandom_range(0, 99) < 25);
            fetch_ready_i = ($urandom_range(0, 99) < 70);
            trap_i        = ($urandom_range(0, 99) < 5);
            br_taken_i    = ($urandom_range(0, 99) < 10);
            jmp_i         = ($urandom_range(0, 99) < 10);
            halt_i        = ($urandom_range(0, 99) < 8);
            br_target_i   = $urandom & 32'hFFFF_FFFE;
            jmp_target_i  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It succeeds the fixed PC+4 adder.
- Holds the PC register and its reset vector.
- Computes the sequential increment at configurable width and step.
- Arbitrates trap, branch and jump redirects.
- Offers each PC to instruction fetch through a valid/ready handshake, with stall and halt (wait-for-interrupt) support.

Parameters:
XLEN, 32, PC and target width in bits
INC, 4, sequential increment in bytes
RESET_VEC, 32'h0000_0000, PC loaded by reset (XLEN bits)
TRAP_VEC, 32'h0000_0100, PC loaded on trap (XLEN bits)
ALIGN_BITS, 2, low PC bits that must be zero for an aligned target

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  synchronous, active-high reset
stall_i  input  1  pipeline stall; blocks sequential advance only
fetch_ready_i  input  1  fetch accepts pc_o this cycle
br_taken_i  input  1  branch-taken redirect request
br_target_i  input  XLEN  branch target
jmp_i  input  1  jump redirect request
jmp_target_i  input  XLEN  jump target
trap_i  input  1  trap/interrupt redirect to TRAP_VEC
halt_i  input  1  enter halt (wait-for-interrupt)
pc_o  output  XLEN  current PC
pc_inc_o  output  XLEN  pc_o + INC, modulo 2^XLEN, combinational
pc_valid_o  output  1  pc_o offered to fetch
misalign_o  output  1  last loaded redirect target was misaligned
halted_o  output  1  FSM is in HALT

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: pc_o=RESET_VEC, pc_valid_o=0, misalign_o=0, halted_o=0, state=BOOT.
- rst has top priority and aborts any state, including HALT or a pending redirect.
- FSM states:
  - BOOT: one cycle with valid=0, then unconditionally to RUN.
  - RUN: valid=1.
  - HALT: valid=0, PC held.
- Next-PC priority (RUN): trap_i > br_taken_i > jmp_i > sequential > hold.
  - Redirects load the target at the next edge, regardless of fetch_ready_i and stall_i. This is a zero-bubble redirect: valid stays 1.
  - Sequential advance (pc_o <= pc_inc_o) happens only when pc_valid_o && fetch_ready_i && !stall_i.
  - Otherwise hold; pc_o stays stable while valid=1 and not accepted.
- Arithmetic: the increment wraps modulo 2^XLEN. XLEN'hFFFF_FFFC + 4 gives 0; no carry flag.
- misalign_o is registered.
  - Set when a loaded target has any of the low ALIGN_BITS bits nonzero.
  - Cleared by the next aligned redirect or by rst.
  - The target is loaded unmodified. TRAP_VEC counts as a redirect target.
- halt_i in RUN, with no same-cycle redirect: go to HALT, PC holds.
- halt_i in the same cycle as a redirect: the redirect is taken first, then the FSM goes to HALT holding the new PC.
- HALT exit:
  - trap_i: load TRAP_VEC, go to RUN.
  - br_taken_i or jmp_i: load the target, go to RUN.
  - stall_i, fetch_ready_i and halt_i are ignored in HALT.
- Redirect during BOOT: loaded, and BOOT still lasts exactly one cycle.

Optional Feature:
PC_PERF_EN
- Defined: adds 32-bit saturating counters redirect_cnt_o (increments per accepted redirect) and stall_cnt_o (increments per RUN cycle with valid && !accepted && no redirect). Both clear on rst.
- Undefined: neither the ports nor the counters exist. Core behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - state enum (BOOT, RUN, HALT);
  - next-PC select enum (SEL_HOLD, SEL_SEQ, SEL_JMP, SEL_BR, SEL_TRAP);
  - default RESET_VEC, TRAP_VEC, INC constants.
- One natural sub-module, pc_next_sel: a combinational priority arbiter producing the select code and next PC. The FSM and PC register stay in pc_gen.

Test Plan:
- Reset and BOOT: rst=1 for 2 cycles, then release with fetch_ready=1.
  - Required: cycle 0 valid=0, pc=0. Then pc sequence 0,4,8,C with valid=1.
- Stall and backpressure: at pc=8, stall_i=1 for 3 cycles, then fetch_ready=0 for 2.
  - Required: pc holds at 8 for 5 cycles, then advances to C.
- Priority: at pc=0x40, trap_i, br_taken (0x200) and jmp (0x300) asserted together.
  - Required: next pc=0x100, misalign=0.
  - Then br_target=0x202 alone: required pc=0x202, misalign=1.
- Wrap: rst with RESET_VEC=0xFFFF_FFF8, fetch_ready=1.
  - Required: pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Halt: halt_i at pc=0x20, then 4 idle cycles with fetch_ready=1, then jmp to 0x80.
  - Required: halted=1 and valid=0 with pc at 0x20 during the idle cycles. Then pc=0x80, valid=1, halted=0.
- Reset mid-halt: assert rst while in HALT.
  - Required: pc=RESET_VEC, halted=0, one BOOT cycle with valid=0, then RUN.
